// File: rtl/epp_host_frontend_if.sv
// Signal bundle between the EPP host pins, the front end and the downstream comm controller.
// master = the front end itself; slave = whatever sits around it (host pins and controller).
interface epp_host_frontend_if;
  logic       eppAstbN;
  logic       eppDstbN;
  logic       eppWrN;
  logic [7:0] eppDataIn;
  logic [7:0] eppDataOut;
  logic       eppDataOe;
  logic       eppWait;
  logic       stbAddr;
  logic       stbData;
  logic       ctrlWr;
  logic [7:0] busEppIn;
  logic [7:0] busEppAddrIn;
  logic [7:0] busEppOut;
  logic       stmBusy;
  logic       errAbort;

  modport master (
    input  eppAstbN, eppDstbN, eppWrN, eppDataIn, busEppOut, stmBusy,
    output eppDataOut, eppDataOe, eppWait, stbAddr, stbData, ctrlWr,
           busEppIn, busEppAddrIn, errAbort
  );

  modport slave (
    output eppAstbN, eppDstbN, eppWrN, eppDataIn, busEppOut, stmBusy,
    input  eppDataOut, eppDataOe, eppWait, stbAddr, stbData, ctrlWr,
           busEppIn, busEppAddrIn, errAbort
  );
endinterface

// File: rtl/epp_host_frontend.sv
// EPP host front end: synchronises host strobes, runs the WAIT handshake and turns each
// host cycle into a registered active-low strobe set for the downstream comm controller.
module epp_host_frontend #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STB_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                rstN,
  epp_host_frontend_if.master bus
);

  localparam int unsigned CNT_W = (STB_CYCLES > 1) ? $clog2(STB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STB_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BUSYWAIT = 3'd1;
  localparam logic [2:0] S_SETUP    = 3'd2;
  localparam logic [2:0] S_PULSE    = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;
  localparam logic [2:0] S_ACK      = 3'd5;

  // Pin synchronisers; idle level of every host control pin is 1
  logic [SYNC_STAGES-1:0] astb_sync_q;
  logic [SYNC_STAGES-1:0] dstb_sync_q;
  logic [SYNC_STAGES-1:0] wrn_sync_q;
  logic                   astb_s;
  logic                   dstb_s;
  logic                   wrn_s;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      astb_sync_q <= '1;
      dstb_sync_q <= '1;
      wrn_sync_q  <= '1;
    end else begin
      astb_sync_q <= {astb_sync_q[SYNC_STAGES-2:0], bus.eppAstbN};
      dstb_sync_q <= {dstb_sync_q[SYNC_STAGES-2:0], bus.eppDstbN};
      wrn_sync_q  <= {wrn_sync_q[SYNC_STAGES-2:0], bus.eppWrN};
    end
  end

  assign astb_s = astb_sync_q[SYNC_STAGES-1];
  assign dstb_s = dstb_sync_q[SYNC_STAGES-1];
  assign wrn_s  = wrn_sync_q[SYNC_STAGES-1];

  logic [2:0]       state_q,      state_d;
  logic             wr_q,         wr_d;
  logic             addr_cyc_q,   addr_cyc_d;
  logic             ign_dstb_q,   ign_dstb_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             stb_addr_q,   stb_addr_d;
  logic             stb_data_q,   stb_data_d;
  logic             ctrl_wr_q,    ctrl_wr_d;
  logic             epp_wait_q,   epp_wait_d;
  logic             epp_oe_q,     epp_oe_d;
  logic             err_abort_q,  err_abort_d;
  logic [7:0]       bus_in_q,     bus_in_d;
  logic [7:0]       addr_q,       addr_d;
  logic [7:0]       data_out_q,   data_out_d;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_cyc_q  <= 1'b0;
      ign_dstb_q  <= 1'b0;
      cnt_q       <= '0;
      stb_addr_q  <= 1'b1;
      stb_data_q  <= 1'b1;
      ctrl_wr_q   <= 1'b1;
      epp_wait_q  <= 1'b0;
      epp_oe_q    <= 1'b0;
      err_abort_q <= 1'b0;
      bus_in_q    <= 8'h00;
      addr_q      <= 8'h00;
      data_out_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_cyc_q  <= addr_cyc_d;
      ign_dstb_q  <= ign_dstb_d;
      cnt_q       <= cnt_d;
      stb_addr_q  <= stb_addr_d;
      stb_data_q  <= stb_data_d;
      ctrl_wr_q   <= ctrl_wr_d;
      epp_wait_q  <= epp_wait_d;
      epp_oe_q    <= epp_oe_d;
      err_abort_q <= err_abort_d;
      bus_in_q    <= bus_in_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
    end
  end

  // Next state; outputs are computed for the state being entered so they register with it
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_cyc_d  = addr_cyc_q;
    ign_dstb_d  = ign_dstb_q & ~dstb_s;
    cnt_d       = cnt_q;
    stb_addr_d  = 1'b1;
    stb_data_d  = 1'b1;
    ctrl_wr_d   = ctrl_wr_q;
    epp_wait_d  = epp_wait_q;
    epp_oe_d    = epp_oe_q;
    err_abort_d = 1'b0;
    bus_in_d    = bus_in_q;
    addr_d      = addr_q;
    data_out_d  = data_out_q;

    case (state_q)
      S_IDLE: begin
        if (!astb_s) begin
          // A data strobe that overlaps an address cycle stays ignored until it is released
          wr_d       = ~wrn_s;
          addr_cyc_d = 1'b1;
          ign_dstb_d = ~dstb_s;
          if (!wrn_s) begin
            addr_d    = bus.eppDataIn;
            bus_in_d  = bus.eppDataIn;
            ctrl_wr_d = 1'b0;
            state_d   = S_SETUP;
          end else begin
            data_out_d = addr_q;
            epp_oe_d   = 1'b1;
            epp_wait_d = 1'b1;
            state_d    = S_ACK;
          end
        end else if (!dstb_s && !ign_dstb_q) begin
          wr_d       = ~wrn_s;
          addr_cyc_d = 1'b0;
          if (!wrn_s) begin
            bus_in_d = bus.eppDataIn;
          end
          state_d = S_BUSYWAIT;
        end
      end

      S_BUSYWAIT: begin
        // Host giving up before service wins over a simultaneous busy release
        if (dstb_s) begin
          err_abort_d = 1'b1;
          state_d     = S_IDLE;
        end else if (!bus.stmBusy) begin
          ctrl_wr_d = ~wr_q;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        cnt_d      = '0;
        stb_addr_d = ~addr_cyc_q;
        stb_data_d = addr_cyc_q;
        state_d    = S_PULSE;
      end

      S_PULSE: begin
        if (cnt_q == CNT_LAST) begin
          if (!wr_q) begin
            data_out_d = bus.busEppOut;
            epp_oe_d   = 1'b1;
          end
          state_d = S_HOLD;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          stb_addr_d = ~addr_cyc_q;
          stb_data_d = addr_cyc_q;
        end
      end

      S_HOLD: begin
        ctrl_wr_d  = 1'b1;
        epp_wait_d = 1'b1;
        state_d    = S_ACK;
      end

      S_ACK: begin
        if (addr_cyc_q ? astb_s : dstb_s) begin
          epp_wait_d = 1'b0;
          epp_oe_d   = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.stbAddr      = stb_addr_q;
  assign bus.stbData      = stb_data_q;
  assign bus.ctrlWr       = ctrl_wr_q;
  assign bus.eppWait      = epp_wait_q;
  assign bus.eppDataOe    = epp_oe_q;
  assign bus.eppDataOut   = data_out_q;
  assign bus.busEppIn     = bus_in_q;
  assign bus.busEppAddrIn = addr_q;
  assign bus.errAbort     = err_abort_q;

endmodule
